// File: rtl/seven_seg_scan_mux.sv
// Four-digit hex scan driver with frame-aligned double buffering; optional SEVEN_SEG_BLANK_LEADING_ZERO_EN blanks leading zeros.
// Latency: an/hex/dp registered one cycle after digit_sel/display; frame_done combinational with the digit-3 tick.
// Backpressure: none; load is a fire-and-forget strobe, last load before a frame boundary wins.
module seven_seg_scan_mux #(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [3:0]  hex,
    output logic [3:0]  an,
    output logic        dp,
    output logic [1:0]  digit_sel,
    output logic        frame_done
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] prescaler;
    logic             tick;
    logic             boundary;
    logic [15:0]      pend_val;
    logic [3:0]       pend_dp;
    logic [15:0]      disp_val;
    logic [3:0]       disp_dp;
    logic [3:0]       blank;
    logic [3:0]       sel_nib;

    assign tick       = (prescaler == LAST);
    assign boundary   = tick && (digit_sel == 2'd3);
    assign frame_done = boundary;
    assign sel_nib    = disp_val[{digit_sel, 2'b00} +: 4];

`ifdef SEVEN_SEG_BLANK_LEADING_ZERO_EN
    // A digit goes dark only if it and every digit to its left is zero and it has no decimal point.
    always_comb begin
        blank    = 4'b0000;
        blank[1] = (disp_val[15:4] == 12'h000) && !disp_dp[1];
        blank[2] = (disp_val[15:8] == 8'h00) && !disp_dp[2];
        blank[3] = (disp_val[15:12] == 4'h0) && !disp_dp[3];
    end
`else
    assign blank = 4'b0000;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            digit_sel <= 2'd0;
            pend_val  <= 16'h0000;
            pend_dp   <= 4'h0;
            disp_val  <= 16'h0000;
            disp_dp   <= 4'h0;
            an        <= 4'b1111;
            hex       <= 4'h0;
            dp        <= 1'b1;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                digit_sel <= digit_sel + 2'd1;
            end
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
            end
            // A load landing on the boundary bypasses pending so it is not delayed a whole frame.
            if (boundary) begin
                disp_val <= load ? value : pend_val;
                disp_dp  <= load ? dp_in : pend_dp;
            end
            an  <= blank[digit_sel] ? 4'b1111 : ~(4'b0001 << digit_sel);
            hex <= sel_nib;
            dp  <= blank[digit_sel] | ~disp_dp[digit_sel];
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Directed bench for seven_seg_scan_mux with a frame-level reference model checked every cycle.
`timescale 1ns/1ps
module tb_seven_seg_scan_mux;
    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;
`ifdef SEVEN_SEG_BLANK_LEADING_ZERO_EN
    localparam bit         BLANK_EN = 1'b1;
    localparam logic [3:0] LIT_0000 = 4'b0001;
    localparam logic [3:0] LIT_0050 = 4'b0011;
    localparam logic [3:0] LIT_DP2  = 4'b0101;
`else
    localparam bit         BLANK_EN = 1'b0;
    localparam logic [3:0] LIT_0000 = 4'b1111;
    localparam logic [3:0] LIT_0050 = 4'b1111;
    localparam logic [3:0] LIT_DP2  = 4'b1111;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        load  = 1'b0;
    logic [3:0]  hex;
    logic [3:0]  an;
    logic        dp;
    logic [1:0]  digit_sel;
    logic        frame_done;

    int checks = 0;
    int passed = 0;
    int fd     = 0;
    logic [15:0] seen = 16'h0000;

    seven_seg_scan_mux #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
        .hex(hex), .an(an), .dp(dp), .digit_sel(digit_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: mc counts clock edges since reset release; slot and frame follow by division.
    int          mc     = 0;
    logic [15:0] m_pend = 16'h0000;
    logic [3:0]  m_pdp  = 4'h0;
    logic [15:0] m_disp = 16'h0000;
    logic [3:0]  m_ddp  = 4'h0;
    logic [3:0]  m_an   = 4'b1111;
    logic [3:0]  m_hex  = 4'h0;
    logic        m_dp   = 1'b1;
    int          m_d;
    logic        m_blank;

    function automatic logic is_blank(input logic [15:0] v, input logic [3:0] d, input int k);
        return BLANK_EN && (k > 0) && ((v >> (4 * k)) == 16'h0000) && !d[k];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mc = 0; m_pend = 16'h0000; m_pdp = 4'h0; m_disp = 16'h0000; m_ddp = 4'h0;
            m_an = 4'b1111; m_hex = 4'h0; m_dp = 1'b1;
        end else begin
            m_d     = (mc / DIV) % 4;
            m_blank = is_blank(m_disp, m_ddp, m_d);
            m_an    = 4'b1111;
            if (!m_blank) m_an[m_d] = 1'b0;
            m_hex   = m_disp[4 * m_d +: 4];
            m_dp    = m_blank ? 1'b1 : !m_ddp[m_d];
            if (load) begin m_pend = value; m_pdp = dp_in; end
            if (mc % FRAME == FRAME - 1) begin m_disp = m_pend; m_ddp = m_pdp; end
            mc++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("model_an", {12'h0, an}, {12'h0, m_an});
            check("model_hex", {12'h0, hex}, {12'h0, m_hex});
            check("model_dp", {15'h0, dp}, {15'h0, m_dp});
            check("model_sel", {14'h0, digit_sel}, 16'((mc / DIV) % 4));
            check("model_fd", {15'h0, frame_done}, {15'h0, (mc % FRAME == FRAME - 1)});
        end
    end

    task automatic wait_mod(input int m);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((mc % FRAME != m) && (n < 4 * FRAME));
        check("wait_phase", 16'(mc % FRAME), 16'(m));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v; dp_in = d; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Walks one full frame from its first displayed cycle, checking hand-derived slot outputs.
    task automatic show_frame(input string tag, input logic [15:0] v, input logic [3:0] d, input logic [3:0] lit);
        logic [3:0] exp_an;
        int s;
        wait_mod(1);
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            s = i / DIV;
            exp_an = 4'b1111;
            if (lit[s]) exp_an[s] = 1'b0;
            seen[hex] = 1'b1;
            check({tag, "_an"}, {12'h0, an}, {12'h0, exp_an});
            check({tag, "_hex"}, {12'h0, hex}, {12'h0, v[4 * s +: 4]});
            check({tag, "_dp"}, {15'h0, dp}, {15'h0, lit[s] ? !d[s] : 1'b1});
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_an", {12'h0, an}, 16'h000f);
        check("rst_hex", {12'h0, hex}, 16'h0000);
        check("rst_dp", {15'h0, dp}, 16'h0001);
        check("rst_fd", {15'h0, frame_done}, 16'h0000);
        reset = 1'b0;
        @(negedge clk);
        check("first_an", {12'h0, an}, 16'h000e);
        check("first_hex", {12'h0, hex}, 16'h0000);
        check("first_dp", {15'h0, dp}, 16'h0001);
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (frame_done) fd++;
        end
        check("fd_count", 16'(fd), 16'd2);
        show_frame("idle", 16'h0000, 4'h0, LIT_0000);

        wait_mod(5);
        do_load(16'hA3F5, 4'b0100);
        wait_mod(13);
        check("hold_an", {12'h0, an}, 16'h0007);
        check("hold_hex", {12'h0, hex}, 16'h0000);
        show_frame("a3f5", 16'hA3F5, 4'b0100, 4'b1111);

        wait_mod(15);
        do_load(16'h1234, 4'h0);
        show_frame("coincide", 16'h1234, 4'h0, 4'b1111);

        wait_mod(3);
        do_load(16'h1111, 4'h0);
        wait_mod(8);
        do_load(16'h2222, 4'h0);
        wait_mod(0);
        seen = 16'h0000;
        show_frame("last_wins", 16'h2222, 4'h0, 4'b1111);
        check("never_1111", {15'h0, seen[1]}, 16'h0000);

        wait_mod(2);
        do_load(16'h9999, 4'hf);
        wait_mod(10);
        #2 reset = 1'b1;
        #1;
        check("async_an", {12'h0, an}, 16'h000f);
        check("async_hex", {12'h0, hex}, 16'h0000);
        check("async_dp", {15'h0, dp}, 16'h0001);
        check("async_sel", {14'h0, digit_sel}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("restart_an", {12'h0, an}, 16'h000e);
        check("restart_hex", {12'h0, hex}, 16'h0000);
        show_frame("post_rst", 16'h0000, 4'h0, LIT_0000);

        wait_mod(4);
        do_load(16'h0050, 4'h0);
        show_frame("v0050", 16'h0050, 4'h0, LIT_0050);
        wait_mod(4);
        do_load(16'h0000, 4'h0);
        show_frame("v0000", 16'h0000, 4'h0, LIT_0000);
        wait_mod(4);
        do_load(16'h0000, 4'b0100);
        show_frame("dp2", 16'h0000, 4'b0100, LIT_DP2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
